// File: rtl/garduino_sys_v1_switch_debouncer.sv
// Purpose : synchronise and debounce the raw slide switches feeding the switch PIO in_port.
// Latency : SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 .. SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles, step to level.
// Backpres: none; all outputs are free-running registered levels/pulses.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   sw_raw        raw switch pins (asynchronous, bouncy)
//   clear_change  one-cycle strobe clearing change_sticky
//   sw_debounced  clean switch levels
//   rise_pulse    per-bit 1-cycle pulse on a committed 0->1
//   fall_pulse    per-bit 1-cycle pulse on a committed 1->0
//   change_pulse  1-cycle pulse when any bit commits
//   change_sticky set on any commit, held until clear_change
module garduino_sys_v1_switch_debouncer #(
  parameter int unsigned      WIDTH        = 18,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      TICK_DIV     = 50000,
  parameter int unsigned      STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clear_change,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_pulse,
  output logic             change_sticky
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   CW        = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

  // Synchroniser: stage 0 captures the pins, the last stage is the usable level.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sw_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // Shared prescaler; with TICK_DIV=1 the count stays at 0 and tick is constant 1.
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-bit stability counters. A counter only advances while the synchronised
  // level disagrees with the committed level; any agreement restarts it, and it
  // is cleared on commit, so it never needs to wrap.
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] commit;

  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    commit = '0;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sw_sync[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          commit[i] = 1'b1;
          deb_d[i]  = sw_sync[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      deb_q <= INIT_VALUE;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  // Edge pulses are registered on the commit edge so they line up with the new level.
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    rise_d   = commit & sw_sync;
    fall_d   = commit & ~sw_sync;
    chg_d    = |commit;
    sticky_d = sticky_q;
    // A commit in the same cycle as a clear must not be lost, so set has priority.
    if (|commit) begin
      sticky_d = 1'b1;
    end else if (clear_change) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q   <= '0;
      fall_q   <= '0;
      chg_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      chg_q    <= chg_d;
      sticky_q <= sticky_d;
    end
  end

  assign sw_debounced  = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign change_pulse  = chg_q;
  assign change_sticky = sticky_q;

endmodule

// File: tb/tb_garduino_sys_v1_switch_debouncer.sv
// Directed bench for the switch debouncer with a short tick (TICK_DIV=4, STABLE_TICKS=3).
module tb_garduino_sys_v1_switch_debouncer;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_change;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_debounced;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         change_pulse;
  logic         change_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  garduino_sys_v1_switch_debouncer #(
    .WIDTH        (W),
    .SYNC_STAGES  (2),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .INIT_VALUE   ('0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_raw        (sw_raw),
    .clear_change  (clear_change),
    .sw_debounced  (sw_debounced),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .change_pulse  (change_pulse),
    .change_sticky (change_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run ncyc cycles, recording the first change_pulse cycle (1-based, 0 if none),
  // the number of change_pulse cycles, the pulses at the first one, and all pulses seen.
  task automatic watch(input int ncyc, output int first, output int npulse,
                       output logic [W-1:0] rise_at, output logic [W-1:0] fall_at,
                       output logic [W-1:0] rise_or, output logic [W-1:0] fall_or);
    first   = 0;
    npulse  = 0;
    rise_at = '0;
    fall_at = '0;
    rise_or = '0;
    fall_or = '0;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      rise_or |= rise_pulse;
      fall_or |= fall_pulse;
      if (change_pulse) begin
        npulse++;
        if (first == 0) begin
          first   = k;
          rise_at = rise_pulse;
          fall_at = fall_pulse;
        end
      end
    end
  endtask

  int           first, npulse, tot_pulse;
  logic [W-1:0] rise_at, fall_at, rise_or, fall_or, rise_acc, fall_acc;
  logic         found, sticky_at;

  initial begin
    reset        = 1'b1;
    clear_change = 1'b0;
    sw_raw       = 18'h3FFFF;

    // 1. Reset with all switches high
    repeat (3) step();
    check("t1_rst_deb",    32'(sw_debounced), 32'h0);
    check("t1_rst_rise",   32'(rise_pulse),   32'h0);
    check("t1_rst_fall",   32'(fall_pulse),   32'h0);
    check("t1_rst_chg",    32'(change_pulse), 32'h0);
    check("t1_rst_sticky", 32'(change_sticky), 32'h0);
    reset = 1'b0;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t1_lat",     32'(first >= 1 && first <= 14), 32'h1);
    check("t1_rise",    32'(rise_at), 32'h3FFFF);
    check("t1_npulse",  32'(npulse), 32'h1);
    check("t1_nofall",  32'(fall_or), 32'h0);
    check("t1_deb",     32'(sw_debounced), 32'h3FFFF);
    check("t1_sticky",  32'(change_sticky), 32'h1);

    // Bring everything back low and clear the flag
    sw_raw = '0;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t1b_fall", 32'(fall_at), 32'h3FFFF);
    check("t1b_deb",  32'(sw_debounced), 32'h0);
    clear_change = 1'b1;
    step();
    clear_change = 1'b0;
    check("t1b_clr", 32'(change_sticky), 32'h0);

    // 2. Clean step on bit 0
    sw_raw[0] = 1'b1;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t2_lat",    32'(first >= 11 && first <= 14), 32'h1);
    check("t2_rise",   32'(rise_at), 32'h1);
    check("t2_npulse", 32'(npulse), 32'h1);
    check("t2_riseor", 32'(rise_or), 32'h1);
    check("t2_deb",    32'(sw_debounced), 32'h1);
    check("t2_sticky", 32'(change_sticky), 32'h1);
    clear_change = 1'b1;
    step();
    clear_change = 1'b0;

    // 3. Bounce on bit 5: toggle every 5 cycles for 60 cycles
    tot_pulse = 0;
    rise_acc  = '0;
    fall_acc  = '0;
    for (int i = 0; i < 12; i++) begin
      sw_raw[5] = ~sw_raw[5];
      watch(5, first, npulse, rise_at, fall_at, rise_or, fall_or);
      tot_pulse += npulse;
      rise_acc  |= rise_or;
      fall_acc  |= fall_or;
    end
    check("t3_nochg",  32'(tot_pulse), 32'h0);
    check("t3_norise", 32'(rise_acc), 32'h0);
    check("t3_nofall", 32'(fall_acc), 32'h0);
    check("t3_deb",    32'(sw_debounced), 32'h1);
    check("t3_sticky", 32'(change_sticky), 32'h0);
    sw_raw[5] = 1'b1;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t3_lat",  32'(first >= 1 && first <= 14), 32'h1);
    check("t3_rise", 32'(rise_at), 32'h20);
    check("t3_deb2", 32'(sw_debounced), 32'h21);

    // 4. Simultaneous rise on bit 1 and fall on bit 17
    sw_raw[17] = 1'b1;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t4_pre", 32'(rise_at), 32'h20000);
    sw_raw[1]  = 1'b1;
    sw_raw[17] = 1'b0;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t4_npulse", 32'(npulse), 32'h1);
    check("t4_rise",   32'(rise_at), 32'h00002);
    check("t4_fall",   32'(fall_at), 32'h20000);
    check("t4_deb",    32'(sw_debounced), 32'h23);

    // 5. clear_change coinciding with a commit: set wins
    clear_change = 1'b1;
    step();
    check("t5_cleared", 32'(change_sticky), 32'h0);
    sw_raw[2] = 1'b1;
    found     = 1'b0;
    sticky_at = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (change_pulse) begin
        found     = 1'b1;
        sticky_at = change_sticky;
      end
    end
    clear_change = 1'b0;
    check("t5_commit",     32'(found), 32'h1);
    check("t5_setwins",    32'(sticky_at), 32'h1);
    step();
    check("t5_held",       32'(change_sticky), 32'h1);
    clear_change = 1'b1;
    step();
    clear_change = 1'b0;
    check("t5_clr_alone",  32'(change_sticky), 32'h0);

    // 6. Reset in the middle of a count on bit 3
    sw_raw[3] = 1'b1;
    watch(8, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t6_norise_pre", 32'(rise_or), 32'h0);
    reset = 1'b1;
    step();
    step();
    check("t6_rst_deb",    32'(sw_debounced), 32'h0);
    check("t6_rst_rise",   32'(rise_pulse), 32'h0);
    check("t6_rst_chg",    32'(change_pulse), 32'h0);
    check("t6_rst_sticky", 32'(change_sticky), 32'h0);
    reset = 1'b0;
    watch(20, first, npulse, rise_at, fall_at, rise_or, fall_or);
    check("t6_lat",  32'(first >= 1 && first <= 14), 32'h1);
    check("t6_rise", 32'(rise_at), 32'h2F);
    check("t6_deb",  32'(sw_debounced), 32'h2F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
